// File: rtl/fn_inverse_search.sv
// Inverse evaluator for x = XNOR(c, a|b), y = a&b: scans all eight {a,b,c}
// inputs, one per clock, and reports which ones produce the latched target pair.
module fn_inverse_search (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       target_x,
  input  logic       target_y,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic [7:0] match_mask,
  output logic [3:0] match_cnt,
  output logic [2:0] first_abc,
  output logic [2:0] last_abc,
  output logic [2:0] scan_idx
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t state;
  logic   tgt_x;
  logic   tgt_y;
  logic   fx;
  logic   fy;
  logic   hit;

  // scan_idx doubles as the scan counter, so the forward copy reads it directly
  always_comb begin
    fx  = ~(scan_idx[0] ^ (scan_idx[2] | scan_idx[1]));
    fy  = scan_idx[2] & scan_idx[1];
    hit = (fx == tgt_x) && (fy == tgt_y);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tgt_x      <= 1'b0;
      tgt_y      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      match_mask <= '0;
      match_cnt  <= '0;
      first_abc  <= '0;
      last_abc   <= '0;
      scan_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            tgt_x      <= target_x;
            tgt_y      <= target_y;
            found      <= 1'b0;
            match_mask <= '0;
            match_cnt  <= '0;
            first_abc  <= '0;
            last_abc   <= '0;
            scan_idx   <= '0;
            busy       <= 1'b1;
            state      <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (hit) begin
            match_mask[scan_idx] <= 1'b1;
            match_cnt            <= match_cnt + 4'd1;
            last_abc             <= scan_idx;
            if (!found) begin
              first_abc <= scan_idx;
              found     <= 1'b1;
            end
          end
          if (scan_idx == 3'd7) begin
            scan_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end else begin
            scan_idx <= scan_idx + 3'd1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fn_inverse_search.sv
// Scoreboard bench for fn_inverse_search: stimulus pushes hand-computed results,
// a negedge monitor pops and compares them on every done pulse.
module tb_fn_inverse_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       target_x;
  logic       target_y;
  logic       busy;
  logic       done;
  logic       found;
  logic [7:0] match_mask;
  logic [3:0] match_cnt;
  logic [2:0] first_abc;
  logic [2:0] last_abc;
  logic [2:0] scan_idx;

  fn_inverse_search dut (
    .clk(clk), .rst(rst), .start(start), .target_x(target_x), .target_y(target_y),
    .busy(busy), .done(done), .found(found), .match_mask(match_mask),
    .match_cnt(match_cnt), .first_abc(first_abc), .last_abc(last_abc),
    .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mask;
    int         cnt;
    int         first;
    int         last;
    int         fnd;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Hand-derived truth table, indexed by {x,y}: (0,0) (0,1) (1,0) (1,1)
  logic [7:0] tbl_mask [4] = '{8'h16, 8'h40, 8'h29, 8'h80};
  int         tbl_cnt  [4] = '{3, 1, 3, 1};
  int         tbl_first[4] = '{1, 6, 0, 7};
  int         tbl_last [4] = '{4, 6, 5, 7};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic x, input logic y);
    exp_t e;
    int k;
    k       = {30'd0, x, y};
    e.mask  = tbl_mask[k];
    e.cnt   = tbl_cnt[k];
    e.first = tbl_first[k];
    e.last  = tbl_last[k];
    e.fnd   = 1;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(done), 0);
    chk({tag, "_found"}, int'(found), 0);
    chk({tag, "_mask"},  int'(match_mask), 0);
    chk({tag, "_cnt"},   int'(match_cnt), 0);
    chk({tag, "_first"}, int'(first_abc), 0);
    chk({tag, "_last"},  int'(last_abc), 0);
    chk({tag, "_idx"},   int'(scan_idx), 0);
  endtask

  // Pulse start for one edge; returns in the first SCAN cycle
  task automatic do_start(input logic x, input logic y);
    @(posedge clk); #1;
    start = 1'b1; target_x = x; target_y = y;
    push_exp(x, y);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
  endtask

  // Monitor: pops on every done pulse and checks results plus framing
  int   busy_run  = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      busy_run  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        exp_t e;
        chk("done_single_cycle", int'(prev_done), 0);
        chk("busy_run_len", busy_run, 8);
        busy_run = 0;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("mask",  int'(match_mask), int'(e.mask));
          chk("cnt",   int'(match_cnt), e.cnt);
          chk("first", int'(first_abc), e.first);
          chk("last",  int'(last_abc), e.last);
          chk("found", int'(found), e.fnd);
          chk("busy_at_done", int'(busy), 0);
        end
      end
      prev_done = done;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; target_x = 1'b0; target_y = 1'b0;
    idle(2); #1;
    check_zero("reset");
    rst = 1'b0;
    idle(2);

    // Target (1,0) with per-cycle timing checks
    do_start(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("scan_busy", int'(busy), 1);
      chk("scan_idx", int'(scan_idx), i);
      chk("scan_no_done", int'(done), 0);
      @(posedge clk); #1;
    end
    chk("done_at_k9", int'(done), 1);
    @(posedge clk); #1;
    chk("done_cleared", int'(done), 0);
    idle(3); #1;
    chk("hold_mask", int'(match_mask), 8'h29);
    chk("hold_cnt", int'(match_cnt), 3);

    do_start(1'b0, 1'b0); idle(12);
    do_start(1'b0, 1'b1); idle(12);
    do_start(1'b1, 1'b1); idle(12);

    // Start re-asserted with a different target during SCAN must be ignored
    do_start(1'b1, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; target_x = 1'b1; target_y = 1'b1;
    idle(3); #1;
    start = 1'b0; target_x = 1'b0; target_y = 1'b1;
    idle(12);

    // Asynchronous reset at scan_idx 4 aborts the scan without a done pulse
    do_start(1'b0, 1'b0);
    for (int i = 0; i < 20 && !(busy && scan_idx == 3'd4); i++) @(negedge clk);
    chk("reach_idx4", int'(scan_idx), 4);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    sb.delete();
    idle(2); #1;
    rst = 1'b0;
    idle(4); #1;
    chk("post_rst_idle_busy", int'(busy), 0);
    do_start(1'b1, 1'b0); idle(12);

    // Start held for 30 cycles gives three back-to-back scans
    @(posedge clk); #1;
    start = 1'b1; target_x = 1'b0; target_y = 1'b0;
    for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b0);
    idle(30); #1;
    start = 1'b0;
    idle(12);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
